// File: rtl/histogram_readout.sv
`default_nettype none
// ============================================================================
//  Module      : histogram_readout
//  Description : Streams every bin of a histogram-chain memory out on a
//                valid/ready port after the collect window closes, and
//                optionally zeroes each bin once it has been transferred.
//  Revision    : 1.0 - initial release
// ============================================================================
module histogram_readout #(
    parameter int BINS          = 16,
    parameter int COUNT_W       = 16,
    parameter int CLEAR_ON_READ = 1,
    localparam int AW           = $clog2(BINS)
) (
    input  logic                  clk350,
    input  logic                  rstn,
    input  logic                  collect,
    output logic                  mem_rd_en,
    output logic [AW-1:0]         mem_rd_addr,
    input  logic [COUNT_W-1:0]    mem_rd_data,
    output logic                  mem_clr_we,
    output logic [AW-1:0]         mem_clr_addr,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [COUNT_W-1:0]    m_data,
    output logic [AW-1:0]         m_bin,
    output logic                  m_last,
    output logic [COUNT_W+AW-1:0] total,
    output logic                  done,
    output logic                  busy,
    output logic                  overrun
);

    // The per-bin "next" step is folded into the transition out of OUT/CLR,
    // so a bin costs RD+LAT+OUT(+CLR) cycles.
    localparam logic [2:0] c_idle = 3'd0;
    localparam logic [2:0] c_rd   = 3'd1;
    localparam logic [2:0] c_lat  = 3'd2;
    localparam logic [2:0] c_out  = 3'd3;
    localparam logic [2:0] c_clr  = 3'd4;

    localparam logic [AW-1:0] c_last_bin = AW'(BINS - 1);

    logic [2:0]            state_q,        state_d;
    logic [AW-1:0]         idx_q,          idx_d;
    logic                  collect_q,      collect_d;
    logic                  mem_rd_en_q,    mem_rd_en_d;
    logic [AW-1:0]         mem_rd_addr_q,  mem_rd_addr_d;
    logic                  mem_clr_we_q,   mem_clr_we_d;
    logic [AW-1:0]         mem_clr_addr_q, mem_clr_addr_d;
    logic                  m_valid_q,      m_valid_d;
    logic [COUNT_W-1:0]    m_data_q,       m_data_d;
    logic [AW-1:0]         m_bin_q,        m_bin_d;
    logic                  m_last_q,       m_last_d;
    logic [COUNT_W+AW-1:0] total_q,        total_d;
    logic                  done_q,         done_d;
    logic                  busy_q,         busy_d;
    logic                  overrun_q,      overrun_d;

    logic start;
    logic collect_rise;
    logic advance;

    assign start        = (state_q == c_idle) && collect_q && !collect;
    assign collect_rise = !collect_q && collect;

    // Next-state and registered-output computation for the readout sequencer.
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        collect_d      = collect;
        mem_rd_en_d    = 1'b0;
        mem_rd_addr_d  = mem_rd_addr_q;
        mem_clr_we_d   = 1'b0;
        mem_clr_addr_d = mem_clr_addr_q;
        m_valid_d      = m_valid_q;
        m_data_d       = m_data_q;
        m_bin_d        = m_bin_q;
        m_last_d       = m_last_q;
        total_d        = total_q;
        done_d         = 1'b0;
        busy_d         = busy_q;
        overrun_d      = overrun_q;
        advance        = 1'b0;

        // A new window opening during a readout is flagged but not acted on.
        if (busy_q && collect_rise) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            c_idle: begin
                if (start) begin
                    idx_d         = '0;
                    total_d       = '0;
                    overrun_d     = 1'b0;
                    busy_d        = 1'b1;
                    mem_rd_en_d   = 1'b1;
                    mem_rd_addr_d = '0;
                    state_d       = c_rd;
                end
            end
            c_rd: begin
                state_d = c_lat;
            end
            c_lat: begin
                m_data_d  = mem_rd_data;
                m_bin_d   = idx_q;
                m_last_d  = (idx_q == c_last_bin);
                m_valid_d = 1'b1;
                state_d   = c_out;
            end
            c_out: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    total_d   = total_q + {{AW{1'b0}}, m_data_q};
                    if (CLEAR_ON_READ != 0) begin
                        mem_clr_we_d   = 1'b1;
                        mem_clr_addr_d = idx_q;
                        state_d        = c_clr;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            c_clr: begin
                advance = 1'b1;
            end
            default: begin
                state_d = c_idle;
            end
        endcase

        // Move to the next bin, or finish after the last one.
        if (advance) begin
            if (idx_q == c_last_bin) begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = c_idle;
            end else begin
                idx_d         = idx_q + AW'(1);
                mem_rd_en_d   = 1'b1;
                mem_rd_addr_d = idx_q + AW'(1);
                state_d       = c_rd;
            end
        end
    end

    // State and output registers; reset drops everything to zero at once.
    always_ff @(posedge clk350 or negedge rstn) begin
        if (!rstn) begin
            state_q        <= c_idle;
            idx_q          <= '0;
            collect_q      <= 1'b0;
            mem_rd_en_q    <= 1'b0;
            mem_rd_addr_q  <= '0;
            mem_clr_we_q   <= 1'b0;
            mem_clr_addr_q <= '0;
            m_valid_q      <= 1'b0;
            m_data_q       <= '0;
            m_bin_q        <= '0;
            m_last_q       <= 1'b0;
            total_q        <= '0;
            done_q         <= 1'b0;
            busy_q         <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            collect_q      <= collect_d;
            mem_rd_en_q    <= mem_rd_en_d;
            mem_rd_addr_q  <= mem_rd_addr_d;
            mem_clr_we_q   <= mem_clr_we_d;
            mem_clr_addr_q <= mem_clr_addr_d;
            m_valid_q      <= m_valid_d;
            m_data_q       <= m_data_d;
            m_bin_q        <= m_bin_d;
            m_last_q       <= m_last_d;
            total_q        <= total_d;
            done_q         <= done_d;
            busy_q         <= busy_d;
            overrun_q      <= overrun_d;
        end
    end

    assign mem_rd_en    = mem_rd_en_q;
    assign mem_rd_addr  = mem_rd_addr_q;
    assign mem_clr_we   = mem_clr_we_q;
    assign mem_clr_addr = mem_clr_addr_q;
    assign m_valid      = m_valid_q;
    assign m_data       = m_data_q;
    assign m_bin        = m_bin_q;
    assign m_last       = m_last_q;
    assign total        = total_q;
    assign done         = done_q;
    assign busy         = busy_q;
    assign overrun      = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_histogram_readout.sv
`default_nettype none
// ============================================================================
//  Module      : tb_histogram_readout
//  Description : Scoreboard bench for histogram_readout (BINS=4), one
//                instance clearing on read and one read-only instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_histogram_readout;

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  bin;
        logic        last;
    } exp_t;

    logic clk = 1'b0;
    logic rstn;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- clear-on-read instance ----------------
    logic        collect, mem_rd_en, mem_clr_we, m_valid, m_ready, m_last, done, busy, overrun;
    logic [1:0]  mem_rd_addr, mem_clr_addr, m_bin;
    logic [15:0] mem_rd_data, m_data;
    logic [17:0] total;

    histogram_readout #(.BINS(4), .COUNT_W(16), .CLEAR_ON_READ(1)) dut (
        .clk350(clk), .rstn(rstn), .collect(collect),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .mem_clr_we(mem_clr_we), .mem_clr_addr(mem_clr_addr),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_bin(m_bin),
        .m_last(m_last), .total(total), .done(done), .busy(busy), .overrun(overrun)
    );

    // ---------------- read-only instance ----------------
    logic        collect_nc, mem_rd_en_nc, mem_clr_we_nc, m_valid_nc, m_last_nc, done_nc, busy_nc, overrun_nc;
    logic        m_ready_nc = 1'b1;
    logic [1:0]  mem_rd_addr_nc, mem_clr_addr_nc, m_bin_nc;
    logic [15:0] mem_rd_data_nc, m_data_nc;
    logic [17:0] total_nc;

    histogram_readout #(.BINS(4), .COUNT_W(16), .CLEAR_ON_READ(0)) dut_nc (
        .clk350(clk), .rstn(rstn), .collect(collect_nc),
        .mem_rd_en(mem_rd_en_nc), .mem_rd_addr(mem_rd_addr_nc), .mem_rd_data(mem_rd_data_nc),
        .mem_clr_we(mem_clr_we_nc), .mem_clr_addr(mem_clr_addr_nc),
        .m_valid(m_valid_nc), .m_ready(m_ready_nc), .m_data(m_data_nc), .m_bin(m_bin_nc),
        .m_last(m_last_nc), .total(total_nc), .done(done_nc), .busy(busy_nc), .overrun(overrun_nc)
    );

    // ---------------- bin memories (1-cycle read latency) ----------------
    logic [15:0] mem [4];
    logic [15:0] mem_nc [4];
    logic [15:0] load_val [4];
    logic        load, load_nc;

    always @(posedge clk) begin
        if (load) mem <= load_val;
        else begin
            if (mem_rd_en)  mem_rd_data <= mem[mem_rd_addr];
            if (mem_clr_we) mem[mem_clr_addr] <= 16'd0;
        end
        if (load_nc) mem_nc <= load_val;
        else begin
            if (mem_rd_en_nc)  mem_rd_data_nc <= mem_nc[mem_rd_addr_nc];
            if (mem_clr_we_nc) mem_nc[mem_clr_addr_nc] <= 16'd0;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- m_ready driver ----------------
    int rmode = 0;   // 0: always ready, 1: stall 5 cycles per beat, 2: stall on bin 2
    int vcnt = 0;
    always @(posedge clk) begin
        #1;
        if (m_valid) vcnt++; else vcnt = 0;
        case (rmode)
            1:       m_ready = (vcnt > 5);
            2:       m_ready = !(m_valid && m_bin == 2'd2);
            default: m_ready = 1'b1;
        endcase
    end

    // ---------------- scoreboards and monitors ----------------
    exp_t exp_q[$];
    exp_t exp_nc_q[$];
    int   xfer = 0, dones = 0, xfer_nc = 0, dones_nc = 0;
    int   first_rd = -1, first_val = -1, last_rd = -1, last_rd_nc = -1;
    bit   gap_en = 0, busy_seen = 0, clr_seen_nc = 0;
    logic        prev_v = 0, prev_r = 0;
    logic [15:0] prev_d = 0;
    logic [1:0]  prev_b = 0;

    always @(negedge clk) begin
        exp_t e;
        if (!rstn) begin
            prev_v = 1'b0;
        end else begin
            if (mem_rd_en || mem_clr_we) chk("rd_clr_exclusive", mem_rd_en & mem_clr_we, 0);
            if (mem_rd_en) begin
                if (first_rd < 0) first_rd = cyc;
                if (gap_en && last_rd >= 0) chk("bin_period_clr", cyc - last_rd, 4);
                last_rd = cyc;
            end
            if (m_valid && first_val < 0) first_val = cyc;
            if (prev_v && !prev_r) begin
                chk("hold_valid", m_valid, 1);
                chk("hold_data", m_data, prev_d);
                chk("hold_bin", m_bin, prev_b);
            end
            if (m_valid && m_ready) begin
                xfer++;
                if (exp_q.size() == 0) chk("unexpected_xfer", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("m_data", m_data, e.data);
                    chk("m_bin", m_bin, e.bin);
                    chk("m_last", m_last, e.last);
                end
            end
            if (done) dones++;
            if (busy) busy_seen = 1;
            prev_v = m_valid; prev_r = m_ready; prev_d = m_data; prev_b = m_bin;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rstn) begin
            if (mem_clr_we_nc) clr_seen_nc = 1;
            if (mem_rd_en_nc) begin
                if (last_rd_nc >= 0) chk("bin_period_ro", cyc - last_rd_nc, 3);
                last_rd_nc = cyc;
            end
            if (m_valid_nc && m_ready_nc) begin
                xfer_nc++;
                if (exp_nc_q.size() == 0) chk("unexpected_xfer_ro", 1, 0);
                else begin
                    e = exp_nc_q.pop_front();
                    chk("m_data_ro", m_data_nc, e.data);
                    chk("m_bin_ro", m_bin_nc, e.bin);
                    chk("m_last_ro", m_last_nc, e.last);
                end
            end
            if (done_nc) dones_nc++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic load_mem(input bit ro, input logic [15:0] a, b, c, d);
        @(posedge clk); #1;
        load_val[0] = a; load_val[1] = b; load_val[2] = c; load_val[3] = d;
        if (ro) load_nc = 1'b1; else load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0; load_nc = 1'b0;
    endtask

    task automatic push4(input bit ro, input logic [15:0] a, b, c, d);
        logic [15:0] v [4];
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        for (int i = 0; i < 4; i++) begin
            if (ro) exp_nc_q.push_back('{v[i], 2'(i), i == 3});
            else    exp_q.push_back('{v[i], 2'(i), i == 3});
        end
    endtask

    task automatic wait_done(input string name, input bit ro);
        bit got = 0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (ro ? done_nc : done) got = 1;
        end
        chk(name, got, 1);
    endtask

    task automatic drop_collect(output int edge_cyc);
        collect = 1'b1;
        repeat (2) @(posedge clk);
        #1 collect = 1'b0;
        edge_cyc = cyc;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int  edge_cyc;
        bit  got;
        rstn = 1'b0; collect = 1'b0; collect_nc = 1'b0; m_ready = 1'b1;
        load = 1'b0; load_nc = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {mem_rd_en, mem_rd_addr, mem_clr_we, mem_clr_addr, m_valid, m_data,
                              m_bin, m_last, total, done, busy, overrun}, 0);
        @(posedge clk); #1 rstn = 1'b1;

        // Idle with collect low: nothing may start.
        busy_seen = 0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("idle_busy_seen", busy_seen, 0);
        chk("idle_xfers", xfer, 0);

        // Clear-on-read readout, ready always high.
        load_mem(0, 16'd3, 16'd0, 16'd7, 16'd65535);
        push4(0, 16'd3, 16'd0, 16'd7, 16'd65535);
        xfer = 0; dones = 0; first_rd = -1; first_val = -1; last_rd = -1; gap_en = 1;
        drop_collect(edge_cyc);
        wait_done("t1_done", 0);
        gap_en = 0;
        repeat (3) @(negedge clk);
        chk("t1_first_rd_latency", first_rd - edge_cyc, 1);
        chk("t1_first_valid_latency", first_val - first_rd, 2);
        chk("t1_xfers", xfer, 4);
        chk("t1_done_pulses", dones, 1);
        chk("t1_total", total, 65545);
        chk("t1_busy_after", busy, 0);
        chk("t1_mem_cleared", {mem[0], mem[1], mem[2], mem[3]}, 0);
        chk("t1_queue_empty", exp_q.size(), 0);

        // Same data with a 5-cycle stall on every beat.
        load_mem(0, 16'd3, 16'd0, 16'd7, 16'd65535);
        push4(0, 16'd3, 16'd0, 16'd7, 16'd65535);
        xfer = 0; dones = 0; rmode = 1;
        drop_collect(edge_cyc);
        wait_done("t2_done", 0);
        repeat (2) @(negedge clk);
        rmode = 0;
        chk("t2_xfers", xfer, 4);
        chk("t2_total", total, 65545);
        chk("t2_queue_empty", exp_q.size(), 0);

        // Read-only instance: memory untouched, no clear strobes.
        load_mem(1, 16'd3, 16'd0, 16'd7, 16'd65535);
        push4(1, 16'd3, 16'd0, 16'd7, 16'd65535);
        collect_nc = 1'b1;
        repeat (2) @(posedge clk);
        #1 collect_nc = 1'b0;
        wait_done("t3_done", 1);
        repeat (2) @(negedge clk);
        chk("t3_clr_never", clr_seen_nc, 0);
        chk("t3_mem_unchanged", {mem_nc[0], mem_nc[1], mem_nc[2], mem_nc[3]},
            {16'd3, 16'd0, 16'd7, 16'd65535});
        chk("t3_xfers", xfer_nc, 4);
        chk("t3_total", total_nc, 65545);

        // Overrun: collect rises during bin 1, readout still completes.
        load_mem(0, 16'd1, 16'd2, 16'd3, 16'd4);
        push4(0, 16'd1, 16'd2, 16'd3, 16'd4);
        xfer = 0; dones = 0;
        drop_collect(edge_cyc);
        got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (m_valid && m_bin == 2'd1) got = 1;
        end
        chk("t4_reach_bin1", got, 1);
        collect = 1'b1;
        wait_done("t4_done", 0);
        repeat (2) @(negedge clk);
        chk("t4_overrun_set", overrun, 1);
        chk("t4_xfers", xfer, 4);
        chk("t4_total", total, 10);
        push4(0, 16'd0, 16'd0, 16'd0, 16'd0);
        @(posedge clk); #1 collect = 1'b0;
        repeat (3) @(negedge clk);
        chk("t4_restart_busy", busy, 1);
        chk("t4_overrun_cleared", overrun, 0);
        wait_done("t4_done2", 0);
        @(negedge clk);
        chk("t4_total2", total, 0);

        // Reset while bin 2 waits in OUT.
        load_mem(0, 16'd5, 16'd6, 16'd7, 16'd8);
        exp_q.push_back('{16'd5, 2'd0, 1'b0});
        exp_q.push_back('{16'd6, 2'd1, 1'b0});
        xfer = 0; rmode = 2;
        drop_collect(edge_cyc);
        got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (m_valid && m_bin == 2'd2) got = 1;
        end
        chk("t5_reach_bin2", got, 1);
        rstn = 1'b0;
        #1;
        chk("t5_outputs_zero", {mem_rd_en, mem_rd_addr, mem_clr_we, mem_clr_addr, m_valid, m_data,
                                m_bin, m_last, total, done, busy, overrun}, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("t5_mem", {mem[0], mem[1], mem[2], mem[3]}, {16'd0, 16'd0, 16'd7, 16'd8});
        chk("t5_xfers", xfer, 2);
        chk("t5_queue_empty", exp_q.size(), 0);
        rmode = 0;
        @(posedge clk); #1 rstn = 1'b1;
        repeat (5) @(negedge clk);
        chk("t5_idle_after", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
